// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter/sequencer in front of an N-bank coefficient memory.
//   Requester 0 = NTT compute engine, requester 1 = host load/unload port.
//   The winning beat is registered onto the per-bank memory ports. Read beats
//   carry a one-hot tag down a pipeline so returning data is marked for the
//   requester that issued it.
//
//   Configuration macro: ARB_RR_EN
//     defined   -> round-robin on contention (pointer advances on accept)
//     undefined -> fixed priority, requester 0 wins contention
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/ready [2]      per-requester handshake (ready is combinational)
//   req_lock [2]             hold the grant after this beat
//   req_re [2]               beat contains a read
//   req_we [2*N]             per-requester per-bank write enables
//   req_addr_write/read      per-requester per-bank addresses [2*N*AW]
//   req_din [2*N*DW]         per-requester per-bank write data
//   rsp_valid [2]            one-hot owner of rsp_rdata
//   rsp_rdata [N*DW]         pass-through of mem_dout
//   mem_we/addr_*/din        registered beat to the memory
//   mem_dout [N*DW]          read data from the memory
module mem_port_arbiter #(
    parameter int unsigned N      = 5,
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_lock,
    input  logic [1:0]        req_re,
    input  logic [2*N-1:0]    req_we,
    input  logic [2*N*AW-1:0] req_addr_write,
    input  logic [2*N*AW-1:0] req_addr_read,
    input  logic [2*N*DW-1:0] req_din,
    output logic [1:0]        rsp_valid,
    output logic [N*DW-1:0]   rsp_rdata,
    output logic [N-1:0]      mem_we,
    output logic [N*AW-1:0]   mem_addr_write,
    output logic [N*AW-1:0]   mem_addr_read,
    output logic [N*DW-1:0]   mem_din,
    input  logic [N*DW-1:0]   mem_dout
);

    typedef enum logic [1:0] {
        ST_OPEN,
        ST_LOCK0,
        ST_LOCK1
    } lock_state_t;

    lock_state_t state_q, state_d;
    logic [1:0]  grant;
    logic        accept;
    logic        sel;

`ifdef ARB_RR_EN
    logic        ptr_q, ptr_d;   // requester favoured on the next contention
`endif

    logic [N-1:0]    beat_we;
    logic [N*AW-1:0] beat_aw, beat_ar;
    logic [N*DW-1:0] beat_din;

    // Tag stage 0 lines up with mem_addr_read; RD_LAT further stages line
    // up with mem_dout.
    logic [1:0] tag_q [RD_LAT+1];

    always_comb begin
        grant   = '0;
        state_d = state_q;
`ifdef ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        // A lock owner with valid high takes the cycle outright; an idle
        // owner falls through to normal arbitration in the same cycle.
        unique case (state_q)
            ST_LOCK0: if (req_valid[0]) grant = 2'b01;
            ST_LOCK1: if (req_valid[1]) grant = 2'b10;
            default:  ;
        endcase
        if (grant == '0) begin
            if (req_valid == 2'b11) begin
`ifdef ARB_RR_EN
                grant = ptr_q ? 2'b10 : 2'b01;
`else
                grant = 2'b01;
`endif
            end else begin
                grant = req_valid;
            end
        end

        accept = |grant;
        sel    = grant[1];

        if (accept) begin
            if (req_lock[sel]) state_d = sel ? ST_LOCK1 : ST_LOCK0;
            else               state_d = ST_OPEN;
`ifdef ARB_RR_EN
            ptr_d = ~sel;
`endif
        end else begin
            // No accept while locked means the owner dropped valid.
            state_d = ST_OPEN;
        end

        beat_we  = sel ? req_we[2*N-1:N]            : req_we[N-1:0];
        beat_aw  = sel ? req_addr_write[2*N*AW-1:N*AW] : req_addr_write[N*AW-1:0];
        beat_ar  = sel ? req_addr_read[2*N*AW-1:N*AW]  : req_addr_read[N*AW-1:0];
        beat_din = sel ? req_din[2*N*DW-1:N*DW]     : req_din[N*DW-1:0];
    end

    assign req_ready = grant;
    assign rsp_valid = tag_q[RD_LAT];
    assign rsp_rdata = mem_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_OPEN;
`ifdef ARB_RR_EN
            ptr_q          <= 1'b0;
`endif
            mem_we         <= '0;
            mem_addr_write <= '0;
            mem_addr_read  <= '0;
            mem_din        <= '0;
            for (int unsigned s = 0; s <= RD_LAT; s++) tag_q[s] <= '0;
        end else begin
            state_q <= state_d;
`ifdef ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
            if (accept) begin
                mem_we         <= beat_we;
                mem_addr_write <= beat_aw;
                mem_addr_read  <= beat_ar;
                mem_din        <= beat_din;
            end else begin
                mem_we         <= '0;
                mem_addr_write <= '0;
                mem_addr_read  <= '0;
                mem_din        <= '0;
            end
            // grant is one-hot or zero, so masking with req_re tags only
            // the accepted requester's read.
            tag_q[0] <= grant & req_re;
            for (int unsigned s = 1; s <= RD_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int N = 5, AW = 8, DW = 32, RD_LAT = 1;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid, req_ready, req_lock, req_re, rsp_valid;
    logic [2*N-1:0]    req_we;
    logic [2*N*AW-1:0] req_addr_write, req_addr_read;
    logic [2*N*DW-1:0] req_din;
    logic [N*DW-1:0]   rsp_rdata, mem_din, mem_dout;
    logic [N-1:0]      mem_we;
    logic [N*AW-1:0]   mem_addr_write, mem_addr_read;

    mem_port_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
        .req_re(req_re), .req_we(req_we),
        .req_addr_write(req_addr_write), .req_addr_read(req_addr_read),
        .req_din(req_din),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_we(mem_we), .mem_addr_write(mem_addr_write),
        .mem_addr_read(mem_addr_read), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter: 1-cycle read latency, old data on collision.
    logic [DW-1:0] ram [N][256];
    always @(posedge clk) begin
        for (int b = 0; b < N; b++) begin
            mem_dout[b*DW +: DW] <= ram[b][mem_addr_read[b*AW +: AW]];
            if (mem_we[b] === 1'b1) ram[b][mem_addr_write[b*AW +: AW]] <= mem_din[b*DW +: DW];
        end
    end

    int unsigned checks = 0, errors = 0;

    task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural view of the arbiter plus a shadow of
    // the memory contents as seen by issued beats.
    typedef struct {
        int              due;
        logic [1:0]      who;
        logic [N*DW-1:0] data;
    } rsp_t;

    rsp_t            pend[$];
    logic [DW-1:0]   shadow [N][256];
    bit              m_lk = 0;
    int              m_own = 0, m_ptr = 0, cyc = 0;
    logic [N-1:0]    e_we = '0;
    logic [N*AW-1:0] e_aw = '0, e_ar = '0;
    logic [N*DW-1:0] e_din = '0;
    logic [1:0]      last_ready;

    task automatic cycle();
        int              g;
        logic [N*DW-1:0] rd;
        rsp_t            r;
        #1;
        g = -1;
        if (!rst) begin
            if (m_lk && req_valid[m_own])  g = m_own;
            else if (req_valid == 2'b11)   g = RR ? m_ptr : 0;
            else if (req_valid[0])         g = 0;
            else if (req_valid[1])         g = 1;
            chk("ready", req_ready, (g < 0) ? 0 : (1 << g));
        end
        last_ready = req_ready;

        if (rst) begin
            pend.delete();
            m_lk = 0; m_ptr = 0;
            e_we = '0; e_aw = '0; e_ar = '0; e_din = '0;
        end else if (g < 0) begin
            m_lk = 0;
            e_we = '0; e_aw = '0; e_ar = '0; e_din = '0;
        end else begin
            e_we  = req_we[g*N +: N];
            e_aw  = req_addr_write[g*N*AW +: N*AW];
            e_ar  = req_addr_read[g*N*AW +: N*AW];
            e_din = req_din[g*N*DW +: N*DW];
            if (req_re[g]) begin
                for (int b = 0; b < N; b++) rd[b*DW +: DW] = shadow[b][e_ar[b*AW +: AW]];
                r.due = cyc + 1 + RD_LAT; r.who = 2'(1 << g); r.data = rd;
                pend.push_back(r);
            end
            for (int b = 0; b < N; b++)
                if (e_we[b]) shadow[b][e_aw[b*AW +: AW]] = e_din[b*DW +: DW];
            m_lk = req_lock[g]; m_own = g; m_ptr = 1 - g;
        end

        @(posedge clk); #1;
        cyc++;
        chk("mem_we", mem_we, e_we);
        chk("mem_addr_write", mem_addr_write, e_aw);
        chk("mem_addr_read", mem_addr_read, e_ar);
        chk("mem_din", mem_din, e_din);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            chk("rsp_valid", rsp_valid, pend[0].who);
            chk("rsp_rdata", rsp_rdata, pend[0].data);
            void'(pend.pop_front());
        end else begin
            chk("rsp_valid_idle", rsp_valid, 2'b00);
        end
    endtask

    task automatic set_req(int r, bit v, bit lk, bit rdn, logic [N-1:0] we,
                           int wbase, int rbase, int dbase);
        req_valid[r] = v; req_lock[r] = lk; req_re[r] = rdn;
        req_we[r*N +: N] = we;
        for (int b = 0; b < N; b++) begin
            req_addr_write[(r*N+b)*AW +: AW] = AW'(wbase + b);
            req_addr_read[(r*N+b)*AW +: AW]  = AW'(rbase + b);
            req_din[(r*N+b)*DW +: DW]        = DW'(dbase + b);
        end
    endtask

    task automatic idle_both();
        set_req(0, 0, 0, 0, '0, 0, 0, 0);
        set_req(1, 0, 0, 0, '0, 0, 0, 0);
    endtask

    logic [7:0] gseq;

    initial begin
        for (int b = 0; b < N; b++)
            for (int a = 0; a < 256; a++) begin ram[b][a] = '0; shadow[b][a] = '0; end
        rst = 1'b1;
        idle_both();
        cycle(); cycle();
        rst = 1'b0;

        // Single write from host, then readback.
        set_req(1, 1, 0, 0, 5'b11111, 0, 0, 32'h1000);
        cycle();
        set_req(1, 1, 0, 1, 5'b00000, 0, 0, 0);
        cycle();
        idle_both();
        cycle(); cycle(); cycle();

        // Contention, four cycles.
        gseq = '0;
        set_req(0, 1, 0, 0, 5'b00001, 20, 0, 32'h2000);
        set_req(1, 1, 0, 0, 5'b00010, 30, 0, 32'h3000);
        for (int k = 0; k < 4; k++) begin
            cycle();
            gseq = {gseq[5:0], last_ready};
        end
        chk("contention_seq", gseq, RR ? 8'b01_10_01_10 : 8'b01_01_01_01);

        // Lock: r0 locks for 3 beats then releases; r1 waits throughout.
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1, (k < 3), 0, 5'b00100, 40 + k, 0, 32'h4000 + 16*k);
            cycle();
        end
        set_req(0, 0, 0, 0, '0, 0, 0, 0);
        cycle(); cycle();
        idle_both();
        cycle();

        // Pipelined reads from compute, addresses 0..7.
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1, 0, 1, '0, 0, k, 0);
            cycle();
        end
        idle_both();
        cycle(); cycle(); cycle();

        // Reset while a locked read is in flight.
        set_req(0, 1, 1, 1, '0, 0, 2, 0);
        cycle();
        rst = 1'b1;
        set_req(0, 0, 0, 0, '0, 0, 0, 0);
        set_req(1, 1, 0, 0, 5'b01000, 50, 0, 32'h5000);
        cycle();
        rst = 1'b0;
        cycle(); cycle();
        idle_both();
        cycle();

        // Randomised traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            for (int r = 0; r < 2; r++)
                set_req(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 1) == 1, N'($urandom),
                        $urandom_range(0, 15), $urandom_range(0, 15), int'($urandom));
            rst = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 1'b0;
        idle_both();
        cycle(); cycle(); cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
